// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store front-end: request checking, byte-mask generation for a
// 1-cycle synchronous data memory, load extension and a valid/ready response.
module lsu_mem_ctrl #(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [2:0]    i_req_funct3,
    input  logic [31:0]   i_req_addr,
    input  logic [31:0]   i_req_wdata,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [31:0]   o_rsp_rdata,
    output logic          o_rsp_err,
    output logic [AW-1:0] o_mem_addr,
    output logic [3:0]    o_mem_bmask,
    output logic [31:0]   o_mem_wdata,
    output logic          o_mem_wren,
    input  logic [31:0]   i_mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RSP     = 2'd2
    } state_t;

    // 33-bit bounds so a base near the top of the address space cannot wrap.
    localparam logic [32:0]   RANGE_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0]   RANGE_HI = {1'b0, BASE_ADDR} + 33'(DEPTH) - 33'd4;
    localparam logic [AW-1:0] BASE_OFF = BASE_ADDR[AW-1:0];

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] addr_r;
    logic [2:0]    funct3_r;
    logic          rsp_valid_r;
    logic          rsp_err_r;
    logic [31:0]   rsp_rdata_r;

    logic          idle_s;
    logic          accept_s;
    logic          in_range_s;
    logic          funct3_ok_s;
    logic          legal_s;
    logic [AW-1:0] req_off_s;
    logic [3:0]    bmask_s;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                default:                ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                default:                                ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b010:  r = d;
            3'b100:  r = {24'h00_0000, d[7:0]};
            3'b101:  r = {16'h0000, d[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    assign idle_s      = (state_r == ST_IDLE);
    assign accept_s    = i_req_valid & idle_s;
    assign in_range_s  = ({1'b0, i_req_addr} >= RANGE_LO) && ({1'b0, i_req_addr} <= RANGE_HI);
    assign funct3_ok_s = funct3_legal(i_req_we, i_req_funct3);
    assign legal_s     = in_range_s & funct3_ok_s;
    assign req_off_s   = i_req_addr[AW-1:0] - BASE_OFF;

    assign o_req_ready = idle_s;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_rdata = rsp_rdata_r;
    assign o_rsp_err   = rsp_err_r;
    assign o_mem_wdata = i_req_wdata;

    // Byte mask from the access size; the reserved size encoding touches no byte.
    always_comb begin
        bmask_s = 4'b0000;
        case (i_req_funct3[1:0])
            2'b00:   bmask_s = 4'b0001;
            2'b01:   bmask_s = 4'b0011;
            2'b10:   bmask_s = 4'b1111;
            default: bmask_s = 4'b0000;
        endcase
    end

    // Memory port follows the live request while idle, otherwise parks on the latched offset.
    always_comb begin
        o_mem_addr  = addr_r;
        o_mem_bmask = 4'b0000;
        o_mem_wren  = 1'b0;
        if (idle_s) begin
            o_mem_addr  = req_off_s;
            o_mem_bmask = bmask_s;
            o_mem_wren  = accept_s & i_req_we & legal_s;
        end else begin
            o_mem_addr  = addr_r;
            o_mem_bmask = 4'b0000;
            o_mem_wren  = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (legal_s && !i_req_we) begin
                        state_nxt_s = ST_RD_WAIT;
                    end else begin
                        state_nxt_s = ST_RSP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: state_nxt_s = ST_RSP;
            ST_RSP: begin
                if (i_rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RSP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch and response registers; stores and errors answer without a read.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr_r      <= '0;
            funct3_r    <= 3'b000;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_r   <= req_off_s;
                        funct3_r <= i_req_funct3;
                        if (legal_s && !i_req_we) begin
                            rsp_valid_r <= 1'b0;
                        end else begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= ~legal_s;
                            rsp_rdata_r <= 32'h0000_0000;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    rsp_rdata_r <= load_extend(funct3_r, i_mem_rdata);
                    rsp_err_r   <= 1'b0;
                    rsp_valid_r <= 1'b1;
                end
                ST_RSP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl: a byte-array memory, a transaction-level
// reference model checked every cycle, and directed cases with literal results.
module tb_lsu_mem_ctrl;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          AW    = 12;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_we;
    logic [2:0]    i_req_funct3;
    logic [31:0]   i_req_addr;
    logic [31:0]   i_req_wdata;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [31:0]   o_rsp_rdata;
    logic          o_rsp_err;
    logic [AW-1:0] o_mem_addr;
    logic [3:0]    o_mem_bmask;
    logic [31:0]   o_mem_wdata;
    logic          o_mem_wren;
    logic [31:0]   i_mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 i_clk = ~i_clk;

    lsu_mem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_addr(o_mem_addr), .o_mem_bmask(o_mem_bmask),
        .o_mem_wdata(o_mem_wdata), .o_mem_wren(o_mem_wren),
        .i_mem_rdata(i_mem_rdata)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 2));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment memory, driven only by the DUT memory port.
    logic [7:0]    env_mem [DEPTH];
    logic [AW-1:0] rd_q = '0;
    assign i_mem_rdata = {env_mem[(int'(rd_q) + 3) % DEPTH], env_mem[(int'(rd_q) + 2) % DEPTH],
                          env_mem[(int'(rd_q) + 1) % DEPTH], env_mem[int'(rd_q)]};

    initial begin
        for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_byte(i);
        forever begin
            @(posedge i_clk);
            rd_q <= o_mem_addr;
            if (o_mem_wren) begin
                for (int k = 0; k < 4; k++) begin
                    if (o_mem_bmask[k]) env_mem[(int'(o_mem_addr) + k) % DEPTH] <= o_mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // Reference model: memory image updated from requests, plus response timing.
    logic [7:0] ref_mem [DEPTH];

    function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        longint la = longint'(a);
        longint lo = longint'(BASE);
        bit range_ok = (la >= lo) && (la <= lo + longint'(DEPTH) - 4);
        bit f3_ok    = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return range_ok && f3_ok;
    endfunction

    function automatic int m_offset(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) & longint'(DEPTH - 1));
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input int off);
        longint w = 0;
        longint v;
        for (int k = 0; k < 4; k++) w += longint'(ref_mem[(off + k) % DEPTH]) << (8 * k);
        case (f3)
            3'd0: begin v = w % 256;   if (v >= 128)   v -= 256;   end
            3'd1: begin v = w % 65536; if (v >= 32768) v -= 65536; end
            3'd2: v = w;
            3'd4: v = w % 256;
            3'd5: v = w % 65536;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_bmask(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 4'h1 : (f3[1:0] == 2'd1) ? 4'h3 : 4'hF;
    endfunction

    initial begin
        bit          m_pending = 1'b0;
        int          m_wait    = 0;
        int          m_off     = 0;
        logic [31:0] m_rdata   = 32'h0;
        bit          m_err     = 1'b0;
        bit          lg;
        int          off;
        int          nbytes;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);
        forever begin
            @(negedge i_clk);
            if (!i_reset) begin
                m_pending = 1'b0;
                m_wait    = 0;
                m_rdata   = 32'h0;
                m_err     = 1'b0;
            end
            lg  = m_legal(i_req_we, i_req_funct3, i_req_addr);
            off = m_offset(i_req_addr);
            check("req_ready", o_req_ready, !m_pending);
            check("rsp_valid", o_rsp_valid, m_pending && m_wait == 0);
            if ((m_pending && m_wait == 0) || !i_reset) begin
                check("rsp_rdata", o_rsp_rdata, m_rdata);
                check("rsp_err", o_rsp_err, m_err);
            end
            if (!m_pending) begin
                check("mem_addr", o_mem_addr, off);
                check("mem_wdata", o_mem_wdata, i_req_wdata);
                if (i_req_funct3[1:0] != 2'b11) check("mem_bmask", o_mem_bmask, m_bmask(i_req_funct3));
                check("mem_wren", o_mem_wren, i_req_valid && i_req_we && lg);
            end else begin
                check("mem_wren_busy", o_mem_wren, 1'b0);
                check("mem_bmask_busy", o_mem_bmask, 4'h0);
                if (m_wait > 0) check("mem_addr_rd", o_mem_addr, m_off);
            end
            // Predict the effect of the coming clock edge.
            if (i_reset) begin
                if (!m_pending) begin
                    if (i_req_valid) begin
                        m_pending = 1'b1;
                        m_wait    = 0;
                        m_rdata   = 32'h0;
                        m_err     = !lg;
                        if (lg && i_req_we) begin
                            nbytes = (i_req_funct3 == 3'd0) ? 1 : (i_req_funct3 == 3'd1) ? 2 : 4;
                            for (int k = 0; k < nbytes; k++)
                                ref_mem[(off + k) % DEPTH] = 8'(i_req_wdata >> (8 * k));
                        end else if (lg) begin
                            m_wait  = 1;
                            m_off   = off;
                            m_rdata = m_load(i_req_funct3, off);
                        end
                    end
                end else if (m_wait > 0) begin
                    m_wait--;
                end else if (i_rsp_ready) begin
                    m_pending = 1'b0;
                end
            end
        end
    end

    task automatic junk_req();
        i_req_we     = 1'($urandom);
        i_req_funct3 = 3'($urandom);
        i_req_addr   = $urandom;
        i_req_wdata  = $urandom;
    endtask

    // Present one request (called just after a rising edge) and hold it until accepted.
    task automatic send_req(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            output logic [AW-1:0] ma, output logic [3:0] bm, output logic wr,
                            output logic [31:0] mwd);
        int n = 0;
        i_req_we = we; i_req_funct3 = f3; i_req_addr = a; i_req_wdata = wd;
        i_req_valid = 1'b1;
        @(negedge i_clk);
        while (!o_req_ready && n < 50) begin
            n++;
            @(negedge i_clk);
        end
        if (!o_req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout: request not accepted within 50 cycles");
        end
        ma = o_mem_addr; bm = o_mem_bmask; wr = o_mem_wren; mwd = o_mem_wdata;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        junk_req();
    endtask

    // Wait for the response, stall it for hold cycles with junk requests, then accept it.
    task automatic wait_rsp(input int hold, output logic [31:0] rd, output logic er, output int lat);
        i_rsp_ready = 1'b0;
        lat = 0;
        do begin
            @(negedge i_clk);
            lat++;
        end while (!o_rsp_valid && lat < 50);
        if (!o_rsp_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout: no response within 50 cycles");
        end
        rd = o_rsp_rdata;
        er = o_rsp_err;
        repeat (hold) begin
            @(posedge i_clk);
            #1;
            i_req_valid = 1'($urandom);
            junk_req();
        end
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_rsp_ready = 1'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ma;
        logic [3:0]    bm;
        logic          wr;
        logic [31:0]   mwd;
        logic [31:0]   rd;
        logic          er;
        int            lat;
        bit            we;
        logic [2:0]    f3;
        logic [31:0]   a;

        i_reset = 1'b0; i_req_valid = 1'b0; i_rsp_ready = 1'b0;
        i_req_we = 1'b0; i_req_funct3 = 3'd0; i_req_addr = 32'h0; i_req_wdata = 32'h0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_valid", o_rsp_valid, 1'b0);
        check("rst_rdata", o_rsp_rdata, 32'h0);
        check("rst_err", o_rsp_err, 1'b0);
        check("rst_ready", o_req_ready, 1'b1);
        i_reset = 1'b1;

        send_req(1'b1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, ma, bm, wr, mwd);
        check("sw_addr", ma, 32'd4);
        check("sw_bmask", bm, 4'hF);
        check("sw_wren", wr, 1'b1);
        wait_rsp(0, rd, er, lat);
        check("sw_lat", lat, 32'd1);
        check("sw_err", er, 1'b0);
        check("sw_rdata", rd, 32'h0);

        send_req(1'b0, 3'b010, 32'h0000_2004, 32'h0, ma, bm, wr, mwd);
        check("lw_wren", wr, 1'b0);
        wait_rsp(0, rd, er, lat);
        check("lw_lat", lat, 32'd2);
        check("lw_rdata", rd, 32'hDEAD_BEEF);

        send_req(1'b1, 3'b010, 32'h0000_2007, 32'h0000_80F0, ma, bm, wr, mwd);
        wait_rsp(0, rd, er, lat);
        send_req(1'b0, 3'b000, 32'h0000_2007, 32'h0, ma, bm, wr, mwd);
        wait_rsp(0, rd, er, lat);
        check("lb", rd, 32'hFFFF_FFF0);
        send_req(1'b0, 3'b100, 32'h0000_2007, 32'h0, ma, bm, wr, mwd);
        wait_rsp(1, rd, er, lat);
        check("lbu", rd, 32'h0000_00F0);
        send_req(1'b0, 3'b001, 32'h0000_2007, 32'h0, ma, bm, wr, mwd);
        wait_rsp(0, rd, er, lat);
        check("lh", rd, 32'hFFFF_80F0);
        send_req(1'b0, 3'b101, 32'h0000_2007, 32'h0, ma, bm, wr, mwd);
        wait_rsp(2, rd, er, lat);
        check("lhu", rd, 32'h0000_80F0);

        send_req(1'b1, 3'b000, 32'h0000_2001, 32'h1234_5678, ma, bm, wr, mwd);
        check("sb_bmask", bm, 4'h1);
        check("sb_wdata", mwd, 32'h1234_5678);
        check("sb_addr", ma, 32'd1);
        wait_rsp(0, rd, er, lat);
        send_req(1'b1, 3'b001, 32'h0000_2002, 32'hCAFE_0A0B, ma, bm, wr, mwd);
        check("sh_bmask", bm, 4'h3);
        wait_rsp(0, rd, er, lat);

        send_req(1'b0, 3'b010, 32'h0000_1FFC, 32'h0, ma, bm, wr, mwd);
        check("err_low_wren", wr, 1'b0);
        wait_rsp(0, rd, er, lat);
        check("err_low", {rd[30:0], er}, 32'h1);
        send_req(1'b0, 3'b010, BASE + 32'(DEPTH) - 32'd3, 32'h0, ma, bm, wr, mwd);
        check("err_high_wren", wr, 1'b0);
        wait_rsp(0, rd, er, lat);
        check("err_high", {rd[30:0], er}, 32'h1);
        check("err_high_lat", lat, 32'd1);
        send_req(1'b1, 3'b100, 32'h0000_2010, 32'h5555_AAAA, ma, bm, wr, mwd);
        check("err_sf3_wren", wr, 1'b0);
        wait_rsp(0, rd, er, lat);
        check("err_sf3", {rd[30:0], er}, 32'h1);
        send_req(1'b0, 3'b011, 32'h0000_2010, 32'h0, ma, bm, wr, mwd);
        check("err_lf3_wren", wr, 1'b0);
        wait_rsp(0, rd, er, lat);
        check("err_lf3", {rd[30:0], er}, 32'h1);

        send_req(1'b0, 3'b010, 32'h0000_2007, 32'h0, ma, bm, wr, mwd);
        wait_rsp(4, rd, er, lat);
        check("bp_rdata", rd, 32'h0000_80F0);

        // Reset while a load waits for memory data.
        i_rsp_ready = 1'b0;
        send_req(1'b0, 3'b010, 32'h0000_2004, 32'h0, ma, bm, wr, mwd);
        i_reset = 1'b0;
        #1;
        check("rdw_rst_valid", o_rsp_valid, 1'b0);
        check("rdw_rst_ready", o_req_ready, 1'b1);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        @(negedge i_clk);
        check("rel_ready", o_req_ready, 1'b1);
        repeat (4) begin
            @(negedge i_clk);
            check("rel_no_rsp", o_rsp_valid, 1'b0);
        end
        @(posedge i_clk);
        #1;

        // Reset while a response is stalled.
        i_rsp_ready = 1'b0;
        send_req(1'b0, 3'b010, 32'h0000_1000, 32'h0, ma, bm, wr, mwd);
        check("rsp_pre_rst", o_rsp_valid, 1'b1);
        i_reset = 1'b0;
        #1;
        check("rsp_rst_valid", o_rsp_valid, 1'b0);
        check("rsp_rst_err", o_rsp_err, 1'b0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;

        for (int t = 0; t < 300; t++) begin
            we = 1'($urandom);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
                 (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            case ($urandom_range(0, 9))
                0: a = BASE - 32'($urandom_range(1, 8));
                1: a = BASE + 32'(DEPTH) - 32'd4;
                2: a = BASE + 32'(DEPTH) - 32'd3 + 32'($urandom_range(0, 4));
                3: a = BASE;
                4: a = $urandom;
                5: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                default: a = BASE + 32'($urandom_range(0, DEPTH - 4));
            endcase
            send_req(we, f3, a, $urandom, ma, bm, wr, mwd);
            wait_rsp($urandom_range(0, 3), rd, er, lat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge i_clk);
                #1;
                junk_req();
            end
        end

        repeat (3) @(posedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
